// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI mode-0 initiator for two-byte register transactions; define SPI_REG_MASTER_BYTE_GAP_EN to pause after the command byte
module spi_reg_master #(
  parameter int CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       wr,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss
);
  if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_reg_master: CLK_DIV must be in 3..255");
  end
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP_A, GAP_B, HOLD, GUARD} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GUARD} state_t;
`endif
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, rx, rx_n, rdata_n;
  logic [3:0] bitc, bitc_n;
  logic [15:0] tx, tx_n;
  logic [1:0] miso_q;
  logic tick, last, busy_n, done_n, sclk_n, mosi_n, ss_n;
  assign tick = cnt == 8'd0;
  assign last = bitc == 4'd0;
  // Two-flop synchronizer for the asynchronous MISO line
  always_ff @(posedge clk or posedge reset)
    if (reset) miso_q <= 2'b00;
    else miso_q <= {miso_q[0], miso};
  // Next state and next registered outputs; the GAP and GUARD waits span two phase-counter periods
  always_comb begin
    state_n = state;
    cnt_n = tick ? DIV_M1 : cnt - 8'd1;
    bitc_n = bitc;
    tx_n = tx;
    rx_n = rx;
    rdata_n = rdata;
    busy_n = busy;
    done_n = 1'b0;
    sclk_n = sclk;
    mosi_n = mosi;
    ss_n = ss;
    case (state)
      IDLE: begin
        cnt_n = DIV_M1;
        if (start) begin
          state_n = SETUP;
          tx_n = {wr, addr, wr ? wdata : 8'h00};
          bitc_n = 4'd15;
          busy_n = 1'b1;
          ss_n = 1'b0;
          mosi_n = wr;
        end
      end
      SETUP: state_n = tick ? SHIFT : SETUP;
      SHIFT: if (tick) begin
        sclk_n = !sclk;
        if (sclk) begin
          rx_n = {rx[6:0], miso_q[1]};
          bitc_n = last ? bitc : bitc - 4'd1;
          mosi_n = last ? mosi : tx[bitc - 4'd1];
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
          state_n = last ? HOLD : (bitc == 4'd8) ? GAP_A : SHIFT;
`else
          state_n = last ? HOLD : SHIFT;
`endif
        end
      end
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
      GAP_A: state_n = tick ? GAP_B : GAP_A;
      GAP_B: state_n = tick ? SHIFT : GAP_B;
`endif
      HOLD: if (tick) begin
        state_n = GUARD;
        ss_n = 1'b1;
        done_n = 1'b1;
        rdata_n = rx;
        mosi_n = 1'b0;
        bitc_n = 4'd1;
      end
      GUARD: if (tick) begin
        bitc_n = 4'd0;
        state_n = last ? IDLE : GUARD;
        busy_n = !last;
      end
      default: state_n = IDLE;
    endcase
  end
  // State and output registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= 8'd0;
      bitc <= 4'd0;
      tx <= 16'h0000;
      rx <= 8'h00;
      rdata <= 8'h00;
      busy <= 1'b0;
      done <= 1'b0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      ss <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bitc <= bitc_n;
      tx <= tx_n;
      rx <= rx_n;
      rdata <= rdata_n;
      busy <= busy_n;
      done <= done_n;
      sclk <= sclk_n;
      mosi <= mosi_n;
      ss <= ss_n;
    end
endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: checks spi_reg_master at CLK_DIV 5 and 3 against a timing model and a behavioural SPI slave
`timescale 1ns/1ps
module tb_spi_reg_master;
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  bit fin5 = 1'b0, fin3 = 1'b0;

  task automatic chk(input int cd, input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cd%0d %s: got 0x%0h expected 0x%0h at %0t", cd, name, got, exp, $time);
    end
  endtask

  // cycle offset (from the accepting edge) at which SCLK rises for the k-th transmitted bit
  function automatic int rise(int k, int cd);
    return (2 + 2 * k) * cd + ((GAP != 0 && k >= 8) ? 2 * cd : 0);
  endfunction

  function automatic bit sclk_hi(int c, int cd);
    for (int k = 0; k < 16; k++) if (c >= rise(k, cd) && c < rise(k, cd) + cd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic mosi_at(int c, int cd, logic [15:0] tx);
    for (int k = 0; k < 16; k++) if (c < rise(k, cd) + cd) return tx[15 - k];
    return 1'b0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int CD = (g == 0) ? 5 : 3;
    localparam int L = (34 + 2 * GAP) * CD;
    localparam int BL = L + 2 * CD;
    logic reset = 1'b1, start = 1'b0, wr = 1'b0, miso = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic busy, done, sclk, mosi, ss;
    logic [7:0] rdata;
    int cyc = 0, t0 = 0, c = 0, ndone = 0, ss_run = 0, ss_last = 0, hi_cnt = 0, s_cnt = 0;
    bit act = 1'b0, use_ovr = 1'b0;
    logic [15:0] exp_tx = '0, s_in = '0, s_out = 16'h3C00, last_cmd = '0;
    logic [7:0] exp_rdata = '0, reply = '0, ovr = '0, force_bt = '0;

    spi_reg_master #(.CLK_DIV(CD)) dut (
      .clk(clk), .reset(reset), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss)
    );

    // transaction model: acceptance rule, start time and the byte the slave returned
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        act = 1'b0;
        exp_rdata = 8'h00;
      end else begin
        cyc++;
        if (act && cyc - t0 == L) exp_rdata = reply;
        if (start && (!act || cyc - t0 > BL)) begin
          act = 1'b1;
          t0 = cyc;
          exp_tx = {wr, addr, wr ? wdata : 8'h00};
        end
      end
    end

    // per-cycle compare plus simple activity monitors
    always @(negedge clk) begin
      if (done) ndone++;
      if (!ss) ss_run++;
      else if (ss_run != 0) begin
        ss_last = ss_run;
        ss_run = 0;
      end
      if (!ss && sclk) hi_cnt++;
      if (!reset) begin
        c = cyc - t0;
        chk(CD, "outputs{busy,done,ss,sclk,rdata}", 32'({busy, done, ss, sclk, rdata}),
            32'({act && c < BL, act && c == L, !(act && c < L), act && sclk_hi(c, CD), exp_rdata}));
        if (act && c < rise(15, CD) + CD) chk(CD, "mosi", 32'(mosi), 32'(mosi_at(c, CD, exp_tx)));
      end
    end

    // SPI slave: captures MOSI on SCLK rise, answers reads of 0x00/0x01, random otherwise
    always @(posedge sclk or posedge ss) begin
      if (ss) begin
        if (s_cnt == 16) begin
          last_cmd = s_in;
          chk(CD, "mosi bytes", 32'(s_in), 32'(exp_tx));
          if (s_in[15:8] == 8'h81) force_bt = s_in[7:0];
        end
        s_cnt = 0;
        s_in = '0;
        s_out = {8'($urandom), 8'h00};
      end else begin
        s_in = {s_in[14:0], mosi};
        s_cnt++;
        if (s_cnt == 8) begin
          reply = use_ovr ? ovr : (s_in[7:0] == 8'h00) ? 8'hC1 : (s_in[7:0] == 8'h01) ? force_bt : 8'($urandom);
          s_out[7:0] = reply;
        end
      end
    end

    always @(negedge ss or negedge sclk)
      if (!ss && s_cnt < 16) miso = s_out[15 - s_cnt];

    task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk(CD, "reset outputs", 32'({ss, sclk, mosi, busy, done, rdata}), 32'h1000);
      reset = 1'b0;
      @(negedge clk);
    endtask

    task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d);
      @(negedge clk);
      wr = w;
      addr = a;
      wdata = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < BL) begin
        @(negedge clk);
        lat++;
      end
      chk(CD, "done seen", 32'(done), 1);
    endtask

    task automatic wait_idle();
      int n = 0;
      while (busy && n < BL) begin
        @(negedge clk);
        n++;
      end
      chk(CD, "busy cleared", 32'(busy), 0);
      @(negedge clk);
    endtask

    task automatic rand_txns(input int cnt);
      int lat;
      logic w;
      logic [6:0] a;
      logic [7:0] d;
      for (int i = 0; i < cnt; i++) begin
        w = 1'($urandom);
        a = 7'($urandom_range(0, 3));
        d = 8'($urandom);
        issue(w, a, d);
        wait_done(lat);
        chk(CD, "rand done latency", lat, L);
        if (!w && a == 7'h00) chk(CD, "rand read0", 32'(rdata), 32'hC1);
        wait_idle();
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    endtask

    if (g == 0) begin : g_t5
      initial begin
        int lat, n0;
        do_reset();
        issue(1'b0, 7'h00, 8'hFF);
        wait_done(lat);
        chk(CD, "read0 done latency", lat, GAP ? 180 : 170);
        chk(CD, "read0 rdata", 32'(rdata), 32'hC1);
        wait_idle();
        chk(CD, "read0 ss low cycles", ss_last, GAP ? 180 : 170);
        chk(CD, "read0 mosi", 32'(last_cmd), 32'h0000);
        issue(1'b1, 7'h01, 8'h01);
        wait_done(lat);
        wait_idle();
        chk(CD, "write1 mosi", 32'(last_cmd), 32'h8101);
        chk(CD, "force_bt reg", 32'(force_bt), 32'h01);
        issue(1'b0, 7'h01, 8'h5A);
        wait_done(lat);
        chk(CD, "read1 rdata", 32'(rdata), 32'h01);
        wait_idle();
        chk(CD, "read1 mosi", 32'(last_cmd), 32'h0100);
        n0 = ndone;
        issue(1'b0, 7'h00, 8'h00);
        repeat (9) @(negedge clk);
        addr = 7'h55;
        wr = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (164) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk(CD, "ignored starts done count", ndone - n0, 1);
        chk(CD, "ignored starts mosi", 32'(last_cmd), 32'h0000);
        chk(CD, "ignored starts rdata", 32'(rdata), 32'hC1);
        issue(1'b1, 7'h02, 8'h33);
        repeat (BL - 1) @(negedge clk);
        wr = 1'b0;
        addr = 7'h01;
        start = 1'b1;
        @(negedge clk);
        chk(CD, "start on busy fall ignored", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        chk(CD, "start accepted next cycle", 32'({busy, ss}), 32'h2);
        wait_done(lat);
        chk(CD, "back-to-back latency", lat, GAP ? 180 : 170);
        chk(CD, "back-to-back rdata", 32'(rdata), 32'h01);
        wait_idle();
        n0 = ndone;
        issue(1'b0, 7'h01, 8'h00);
        repeat (60) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk(CD, "async reset outputs", 32'({ss, sclk, mosi, busy, done, rdata}), 32'h1000);
        @(negedge clk);
        reset = 1'b0;
        repeat (BL) @(negedge clk);
        chk(CD, "no done after reset", ndone - n0, 0);
        issue(1'b0, 7'h01, 8'h00);
        wait_done(lat);
        chk(CD, "post-reset latency", lat, GAP ? 180 : 170);
        chk(CD, "post-reset rdata", 32'(rdata), 32'h01);
        wait_idle();
        rand_txns(10);
        fin5 = 1'b1;
      end
    end else begin : g_t3
      initial begin
        int lat, h0;
        do_reset();
        use_ovr = 1'b1;
        ovr = 8'hA5;
        h0 = hi_cnt;
        issue(1'b0, 7'h00, 8'h00);
        wait_done(lat);
        chk(CD, "cd3 done latency", lat, GAP ? 108 : 102);
        chk(CD, "cd3 rdata", 32'(rdata), 32'hA5);
        chk(CD, "cd3 sclk high cycles", hi_cnt - h0, 48);
        wait_idle();
        use_ovr = 1'b0;
        rand_txns(8);
        fin3 = 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 30000 && !(fin5 && fin3); i++) @(negedge clk);
    chk(0, "sequences finished", 32'({fin5, fin3}), 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
